// File: rtl/hazard_fwd_ctrl_if.sv
// rtl/hazard_fwd_ctrl_if.sv - ID-stage hazard/forwarding control bundle
// Purpose: groups the decoded ID-stage fields and the resulting stall/bubble
//          and operand-select controls into one bundle.
// Signals:
//   id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_wen, id_load,
//   id_a_pc, id_b_imm, br_taken  - driven by the pipeline (master)
//   stall, id_ex_clr             - combinational pipeline controls (slave)
//   A1_sel, B1_sel, A2_sel, B2_sel - registered EX-stage mux selects (slave)
interface hazard_fwd_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic [ADDR_W-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_wen;
  logic              id_load;
  logic              id_a_pc;
  logic              id_b_imm;
  logic              br_taken;
  logic              stall;
  logic              id_ex_clr;
  logic              A1_sel;
  logic              B1_sel;
  logic              A2_sel;
  logic              B2_sel;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    output id_wen, id_load, id_a_pc, id_b_imm, br_taken,
    input  stall, id_ex_clr, A1_sel, B1_sel, A2_sel, B2_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    input  id_wen, id_load, id_a_pc, id_b_imm, br_taken,
    output stall, id_ex_clr, A1_sel, B1_sel, A2_sel, B2_sel
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - hazard detection and forwarding control for a 5-stage pipeline
// Purpose: tracks the destination registers of the EX and MEM instructions,
//          stalls ID on load-use and (optionally) distance-2 ALU hazards,
//          squashes ID on a taken branch, and registers the operand mux
//          selects that the instruction uses once it reaches EX.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - hazard_fwd_ctrl_if.slave (ID fields in; stall, id_ex_clr, selects out)
module hazard_fwd_ctrl #(
  parameter int ADDR_W       = 5,
  parameter bit ALU_D2_STALL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_fwd_ctrl_if.slave     bus
);

  // Producer trackers for the instructions currently in EX and MEM.
  logic              ex_v, ex_wen, ex_load;
  logic [ADDR_W-1:0] ex_rd;
  logic              mem_v, mem_wen, mem_load;
  logic [ADDR_W-1:0] mem_rd;

  logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic ex_hit, mem_hit;
  logic ld1, ld2, alu2, haz;
  logic stall_c, clr_c;

  logic a1_q, b1_q, a2_q, b2_q;

  // A producer matches a source only if it really writes a non-x0 register
  // and the ID instruction actually reads that operand.
  always_comb begin
    ex_hit_rs1  = ex_v  & ex_wen  & (ex_rd  != '0) & (ex_rd  == bus.id_rs1) & bus.id_use_rs1;
    ex_hit_rs2  = ex_v  & ex_wen  & (ex_rd  != '0) & (ex_rd  == bus.id_rs2) & bus.id_use_rs2;
    mem_hit_rs1 = mem_v & mem_wen & (mem_rd != '0) & (mem_rd == bus.id_rs1) & bus.id_use_rs1;
    mem_hit_rs2 = mem_v & mem_wen & (mem_rd != '0) & (mem_rd == bus.id_rs2) & bus.id_use_rs2;
    ex_hit      = ex_hit_rs1  | ex_hit_rs2;
    mem_hit     = mem_hit_rs1 | mem_hit_rs2;
  end

  // Load results are not available for forwarding until after MEM, so a
  // load at distance 1 stalls twice (ld1 then ld2) and at distance 2 once.
  // An ALU result at distance 2 is only covered if the regfile bypasses it.
  always_comb begin
    ld1     = bus.id_valid & ex_hit  & ex_load;
    ld2     = bus.id_valid & mem_hit & mem_load;
    alu2    = bus.id_valid & ALU_D2_STALL & mem_hit & ~mem_load;
    haz     = ld1 | ld2 | alu2;
    // A taken branch squashes ID, so the stall would be pointless.
    stall_c = haz & ~bus.br_taken;
    clr_c   = stall_c | bus.br_taken;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v     <= 1'b0;
      ex_wen   <= 1'b0;
      ex_load  <= 1'b0;
      ex_rd    <= '0;
      mem_v    <= 1'b0;
      mem_wen  <= 1'b0;
      mem_load <= 1'b0;
      mem_rd   <= '0;
    end else begin
      mem_v    <= ex_v;
      mem_wen  <= ex_wen;
      mem_load <= ex_load;
      mem_rd   <= ex_rd;
      if (clr_c) begin
        ex_v    <= 1'b0;
        ex_wen  <= 1'b0;
        ex_load <= 1'b0;
        ex_rd   <= '0;
      end else begin
        ex_v    <= bus.id_valid;
        ex_wen  <= bus.id_wen;
        ex_load <= bus.id_load;
        ex_rd   <= bus.id_rd;
      end
    end
  end

  // Selects describe the instruction entering EX. Only distance-1 ALU
  // producers forward; distance-2 values arrive through the regfile. B1 is
  // kept live even with B2 on the immediate because store data uses B1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q <= 1'b0;
      b1_q <= 1'b0;
      a2_q <= 1'b0;
      b2_q <= 1'b0;
    end else if (clr_c) begin
      a1_q <= 1'b0;
      b1_q <= 1'b0;
      a2_q <= 1'b0;
      b2_q <= 1'b0;
    end else begin
      a1_q <= ex_hit_rs1 & ~ex_load;
      b1_q <= ex_hit_rs2 & ~ex_load;
      a2_q <= bus.id_a_pc;
      b2_q <= bus.id_b_imm;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.id_ex_clr = clr_c;
  assign bus.A1_sel    = a1_q;
  assign bus.B1_sel    = b1_q;
  assign bus.A2_sel    = a2_q;
  assign bus.B2_sel    = b2_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Tracks destination registers of the instructions in EX and MEM, and drives the select lines of the operand/forwarding mux block (A1_sel, B1_sel, A2_sel, B2_sel).
- Generates the stall and bubble controls for load-use and distance-2 hazards.
- Squashes the ID instruction on a taken branch.

Parameters:
- ADDR_W, 5, register address width.
- ALU_D2_STALL, 1, 1 = stall one cycle on a distance-2 ALU-producer hazard; 0 = the register file's write-through bypass covers it.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  ADDR_W  source register 1 of ID instruction.
- id_rs2  in  ADDR_W  source register 2 of ID instruction.
- id_rd  in  ADDR_W  destination register of ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2 (ALU operand or store data).
- id_wen  in  1  ID instruction writes rd.
- id_load  in  1  ID instruction is a load.
- id_a_pc  in  1  ALU operand A is the PC.
- id_b_imm  in  1  ALU operand B is the immediate.
- br_taken  in  1  branch/jump resolved taken in EX this cycle.
- stall  out  1  hold PC and IF/ID register (combinational).
- id_ex_clr  out  1  load a bubble into ID/EX (combinational).
- A1_sel  out  1  0 = reg_rs1, 1 = alu forward (registered, valid while the instruction is in EX).
- B1_sel  out  1  0 = reg_rs2, 1 = alu forward; this output also feeds data_w (registered).
- A2_sel  out  1  0 = A1 result, 1 = pc (registered).
- B2_sel  out  1  0 = B1 result, 1 = imm (registered).

Behaviour:
- Internal trackers: EX{v,rd,wen,load} and MEM{v,rd,wen,load}. Every cycle, MEM takes EX, and EX takes ID, or a bubble (v=0) when id_ex_clr=1.
- Reset (async): both trackers invalid. stall=0, id_ex_clr=0, all four selects 0. Asserting rst mid-stall cancels the stall immediately.
- match(T,rs) = T.v & T.wen & (T.rd != 0) & (T.rd == rs), evaluated for rs1 gated by id_use_rs1 and for rs2 gated by id_use_rs2.
- Hazard terms (combinational, gated by id_valid):
  - ld1 = match(EX) & EX.load
  - ld2 = match(MEM) & MEM.load
  - alu2 = ALU_D2_STALL & match(MEM) & !MEM.load
- haz = ld1 | ld2 | alu2.
- stall = haz & !br_taken.
- id_ex_clr = stall | br_taken.
- br_taken has priority over any stall: the ID instruction is squashed and is never stalled.
- Resulting stall counts:
  - Load at distance 1: exactly 2 stall cycles (ld1, then ld2).
  - Load at distance 2: 1 stall cycle.
  - ALU producer at distance 2 with ALU_D2_STALL=1: 1 stall cycle.
  - ALU producer at distance 1: 0 stall cycles, forward instead.
- Select update, at a rising edge when ID advances (id_ex_clr=0):
  - A1_sel <= match(EX,rs1) & !EX.load
  - B1_sel <= match(EX,rs2) & !EX.load
  - A2_sel <= id_a_pc
  - B2_sel <= id_b_imm
- When id_ex_clr=1 at the edge, all four selects are set to 0.
- Selects are independent:
  - A2_sel=1 overrides A1 at the ALU input, but A1_sel is still computed.
  - B1_sel is still driven when B2_sel=1, because store data uses the B1 path.
- Register x0 never forwards and never stalls.
- id_valid=0: no stall. The EX tracker receives v=0.

Test Plan:
- Reset then independent ops: add x5,x1,x2 followed by add x6,x3,x4 -> stall=0; selects at EX = 0,0,0,0.
- ALU distance-1: add x5,.. then sub x7,x5,x5 -> no stall; A1_sel=1, B1_sel=1 in the sub's EX cycle.
- Load-use: lw x5 then add x6,x5,x1 -> stall=1 for exactly 2 cycles; id_ex_clr=1 for the same 2 cycles; then A1_sel=0 (value comes from the regfile bypass).
- Distance-2 ALU, ALU_D2_STALL=1: add x5; nop; addi x6,x5,4 (id_b_imm=1) -> 1 stall cycle; then A1_sel=0, B2_sel=1. Same sequence with ALU_D2_STALL=0 -> 0 stall cycles.
- Branch during stall: lw x5; add x6,x5,x1 with br_taken=1 in the first stall cycle -> stall=0, id_ex_clr=1, selects 0 next cycle.
- Async reset mid-stall: raise rst 2 ns after a load-use stall begins -> stall, id_ex_clr and all selects drop to 0 before the next edge; x0 destination (lw x0 then add x6,x0,x0) -> no stall, no forward.
